// File: rtl/spi_input_conditioner_pkg.sv
// Shared defaults for the SPI input conditioner: filter timing and the
// level each channel rests at while idle or held in reset.
package spi_input_conditioner_pkg;

  localparam int WAIT_TIME_DEF     = 3;
  localparam int COUNTER_WIDTH_DEF = 3;

  // Idle levels: SCLK low (mode 0), CS deselected, MOSI low.
  localparam logic SCLK_IDLE = 1'b0;
  localparam logic CS_IDLE   = 1'b1;
  localparam logic MOSI_IDLE = 1'b0;

endpackage

// File: rtl/spi_input_conditioner_if.sv
// Raw SPI pins in, conditioned levels and edge pulses out. The slave side
// is the conditioner; the master side is whatever drives the pins.
interface spi_input_conditioner_if;

  logic sclk_pin;
  logic cs_pin;
  logic mosi_pin;
  logic sclk_posedge;
  logic sclk_negedge;
  logic cs_cond;
  logic cs_negedge;
  logic mosi_cond;

  modport master (
    output sclk_pin, cs_pin, mosi_pin,
    input  sclk_posedge, sclk_negedge, cs_cond, cs_negedge, mosi_cond
  );

  modport slave (
    input  sclk_pin, cs_pin, mosi_pin,
    output sclk_posedge, sclk_negedge, cs_cond, cs_negedge, mosi_cond
  );

endinterface

// File: rtl/input_conditioner_ch.sv
// One conditioning channel: two-flop synchronizer, consecutive-sample
// glitch filter and registered edge pulses on the filtered level.
module input_conditioner_ch #(
  parameter int   WAIT_TIME     = 3,
  parameter int   COUNTER_WIDTH = 3,
  parameter logic IDLE_VAL      = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic conditioned,
  output logic posedge_p,
  output logic negedge_p
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_LAST = COUNTER_WIDTH'(WAIT_TIME - 1);

  logic                     sync0_q, sync0_d;
  logic                     sync1_q, sync1_d;
  logic                     cond_q,  cond_d;
  logic                     pos_q,   pos_d;
  logic                     neg_q,   neg_d;
  logic [COUNTER_WIDTH-1:0] count_q, count_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    sync0_d = pin;
    sync1_d = sync0_q;
    cond_d  = cond_q;
    count_d = '0;
    pos_d   = 1'b0;
    neg_d   = 1'b0;
    // Any sample that agrees with the accepted level restarts the count.
    if (sync1_q != cond_q) begin
      if (count_q == CNT_LAST) begin
        cond_d = sync1_q;
        pos_d  = sync1_q;
        neg_d  = ~sync1_q;
      end else begin
        count_d = count_q + COUNTER_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking updates so every flop samples pre-edge values.
    if (reset) begin
      sync0_q <= IDLE_VAL;
      sync1_q <= IDLE_VAL;
      cond_q  <= IDLE_VAL;
      count_q <= '0;
      pos_q   <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
      cond_q  <= cond_d;
      count_q <= count_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
    end
  end

  assign conditioned = cond_q;
  assign posedge_p   = pos_q;
  assign negedge_p   = neg_q;

endmodule

// File: rtl/spi_input_conditioner.sv
// Front end for an SPI peripheral: cleans SCLK, CS and MOSI into the clk
// domain and exports only the levels and edges the core consumes.
module spi_input_conditioner
  import spi_input_conditioner_pkg::*;
#(
  parameter int WAIT_TIME     = WAIT_TIME_DEF,
  parameter int COUNTER_WIDTH = COUNTER_WIDTH_DEF
) (
  input logic                    clk,
  input logic                    reset,
  spi_input_conditioner_if.slave spi
);

  // Channel outputs the SPI core never looks at.
  logic sclk_level_unused;
  logic cs_posedge_unused;
  logic mosi_posedge_unused;
  logic mosi_negedge_unused;

  input_conditioner_ch #(
    .WAIT_TIME(WAIT_TIME), .COUNTER_WIDTH(COUNTER_WIDTH), .IDLE_VAL(SCLK_IDLE)
  ) u_sclk (
    .clk(clk), .reset(reset), .pin(spi.sclk_pin),
    .conditioned(sclk_level_unused),
    .posedge_p(spi.sclk_posedge),
    .negedge_p(spi.sclk_negedge)
  );

  input_conditioner_ch #(
    .WAIT_TIME(WAIT_TIME), .COUNTER_WIDTH(COUNTER_WIDTH), .IDLE_VAL(CS_IDLE)
  ) u_cs (
    .clk(clk), .reset(reset), .pin(spi.cs_pin),
    .conditioned(spi.cs_cond),
    .posedge_p(cs_posedge_unused),
    .negedge_p(spi.cs_negedge)
  );

  input_conditioner_ch #(
    .WAIT_TIME(WAIT_TIME), .COUNTER_WIDTH(COUNTER_WIDTH), .IDLE_VAL(MOSI_IDLE)
  ) u_mosi (
    .clk(clk), .reset(reset), .pin(spi.mosi_pin),
    .conditioned(spi.mosi_cond),
    .posedge_p(mosi_posedge_unused),
    .negedge_p(mosi_negedge_unused)
  );

endmodule
